fir_channel_scheduler: RTL and testbench
========================================

FIR_CHANNEL_SCHEDULER -- requirements
Module: fir_channel_scheduler

Interface
REQ-001 Parameters SHALL be: WIDTH, 18, sample/result width; NCH, 4, number of requesting channels; TAPS, 64, engine MAC cycles per sample; TIMEOUT, 80, max cycles waiting for the engine.
REQ-002 Clock, reset and the channel input ports SHALL be:
- clk  input  1  single rising-edge clock
- rst  input  1  asynchronous, active-high reset
- s_valid  input  NCH  per-channel sample offered
- s_data  input  NCH*WIDTH  per-channel signed sample; channel c in bits [c*WIDTH +: WIDTH]
- s_ready  output  NCH  one-hot accept strobe
REQ-003 Engine ports SHALL be:
- eng_start  output  1  one-cycle start pulse to the shared serial FIR engine
- eng_chan  output  log2(NCH)  channel whose delay line the engine uses
- eng_sample  output  WIDTH  sample to push into that delay line
- eng_done  input  1  one-cycle result-valid from the engine
- eng_result  input  WIDTH  signed filtered result
REQ-004 Output and status ports SHALL be:
- m_valid  output  1  result available
- m_ready  input  1  downstream accepts
- m_chan  output  log2(NCH)  channel of the result
- m_data  output  WIDTH  signed result
- err_timeout  output  1  sticky engine-timeout flag
- err_clr  input  1  clears err_timeout

Function
REQ-005 FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, OUT.
REQ-006 IDLE: if any s_valid is high, the block SHALL pick a channel by round-robin, starting at (last_grant+1) mod NCH, drive s_ready high for that channel only in the same cycle, latch its s_data and index, and move to ISSUE.
REQ-007 s_ready SHALL be zero in every state except IDLE; at most one bit SHALL be high in any cycle.
REQ-008 ISSUE: eng_start SHALL be high for exactly one cycle with eng_chan/eng_sample holding the latched values; the next state is WAIT and the watchdog counter clears to 0.
REQ-009 eng_chan and eng_sample SHALL stay stable from ISSUE until the block leaves WAIT.
REQ-010 WAIT: on eng_done, the block SHALL register eng_result into m_data and the latched index into m_chan, then move to OUT; otherwise the watchdog increments by 1.
REQ-011 If the watchdog reaches TIMEOUT-1 with eng_done still low, the block SHALL set err_timeout, discard the sample, and return to IDLE; no m_valid is produced for that sample.
REQ-012 OUT: m_valid SHALL be high and m_data/m_chan stable until m_ready; on the m_valid&&m_ready cycle the block SHALL return to IDLE.
REQ-013 last_grant SHALL update at acceptance (the REQ-006 cycle), so a timed-out channel also loses priority.
REQ-014 eng_done outside WAIT SHALL be ignored.
REQ-015 Latency: accept at cycle 0, eng_start at cycle 1; eng_done at cycle k gives m_valid at cycle k+1. Minimum accept-to-accept spacing SHALL be 4 cycles with m_ready tied high.
REQ-016 err_clr SHALL clear err_timeout; if err_clr and a new timeout occur in the same cycle, the set SHALL win.
REQ-017 No arithmetic is performed on the data path; samples and results SHALL pass bit-exact.

Reset
REQ-018 While rst is high:
- state = IDLE; last_grant = NCH-1, so channel 0 has first priority
- s_ready, eng_start, m_valid, err_timeout = 0
- eng_chan, eng_sample, m_chan, m_data = 0
REQ-019 Reset asserted mid-operation (ISSUE/WAIT/OUT) SHALL abandon the transaction; a later eng_done SHALL be ignored.

Structure
REQ-020 WIDTH, NCH, TAPS, TIMEOUT defaults and the FSM state encoding SHALL live in the shared package fir_pkg.
REQ-021 Round-robin selection SHALL be one sub-module, rr_arbiter (request vector plus last-grant in; one-hot grant and index out, combinational).

Verification
REQ-022 All four s_valid held high, m_ready=1, engine replies 64 cycles after start -> grants in order 0,1,2,3,0; m_chan follows the same order; m_data equals the engine result bit-exact.
REQ-023 Only channel 2 valid, s_data=18'sh1FFFF, engine returns 18'sh3FFFF -> s_ready=0100 at cycle 0, eng_start at cycle 1, m_valid one cycle after eng_done with m_chan=2 and m_data=18'sh3FFFF.
REQ-024 Engine never asserts eng_done -> err_timeout rises at watchdog=79, no m_valid, next grant goes to the following channel; err_clr pulse -> err_timeout=0.
REQ-025 m_ready held low 20 cycles in OUT -> m_valid and data stable; s_ready stays 0 throughout; a spurious eng_done in OUT has no effect.
REQ-026 rst pulsed during WAIT, then eng_done -> all outputs 0, state IDLE, channel 0 granted first afterwards.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared defaults and FSM encoding for the FIR channel scheduler.
package fir_pkg;
  localparam int FIR_WIDTH   = 18;
  localparam int FIR_NCH     = 4;
  localparam int FIR_TAPS    = 64;
  localparam int FIR_TIMEOUT = 80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/fir_channel_scheduler_rr_arbiter.sv
// Combinational round-robin picker: search starts one past the last grant.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_last,
  output logic [NCH-1:0] o_gnt,
  output logic [IW-1:0]  o_idx,
  output logic           o_any
);

  // first requester found walking (last+1) .. (last+NCH) modulo NCH
  always_comb begin : p_rr
    int c;
    c     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      c = (int'(i_last) + i) % NCH;
      if (!o_any && i_req[c]) begin
        o_any    = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one serial FIR engine among NCH sample channels: round-robin accept,
// one-shot engine start, watchdog on the engine reply, held result output.
module fir_channel_scheduler
  import fir_pkg::*;
#(
  parameter int WIDTH   = FIR_WIDTH,
  parameter int NCH     = FIR_NCH,
  parameter int TAPS    = FIR_TAPS,
  parameter int TIMEOUT = FIR_TIMEOUT,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       s_valid,
  input  logic [NCH*WIDTH-1:0] s_data,
  output logic [NCH-1:0]       s_ready,
  output logic                 eng_start,
  output logic [CW-1:0]        eng_chan,
  output logic [WIDTH-1:0]     eng_sample,
  input  logic                 eng_done,
  input  logic [WIDTH-1:0]     eng_result,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CW-1:0]        m_chan,
  output logic [WIDTH-1:0]     m_data,
  output logic                 err_timeout,
  input  logic                 err_clr
);

  // watchdog is sized to hold a full engine run as well as the timeout limit
  localparam int WD_MAX = (TIMEOUT > TAPS) ? TIMEOUT : TAPS;
  localparam int WDW    = $clog2(WD_MAX + 1);

  state_t           r_state;
  logic [CW-1:0]    r_last;
  logic [CW-1:0]    r_chan;
  logic [WIDTH-1:0] r_sample;
  logic             r_start;
  logic [WDW-1:0]   r_wd;
  logic             r_mvalid;
  logic [CW-1:0]    r_mchan;
  logic [WIDTH-1:0] r_mdata;
  logic             r_err;

  logic [NCH-1:0]   w_gnt;
  logic [CW-1:0]    w_idx;
  logic             w_any;
  logic [WIDTH-1:0] w_sel;
  logic             w_timeout;

  rr_arbiter #(.NCH(NCH), .IW(CW)) u_rr (
    .i_req  (s_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // sample of the granted channel (grant is one-hot)
  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NCH; c++)
      if (w_gnt[c]) w_sel = s_data[c*WIDTH +: WIDTH];
  end

  // accept strobe is same-cycle, so it is gated with reset as well as state
  assign s_ready   = (r_state == IDLE && !rst) ? w_gnt : '0;
  assign w_timeout = (r_state == WAIT) && !eng_done && (r_wd == WDW'(TIMEOUT - 1));

  assign eng_start   = r_start;
  assign eng_chan    = r_chan;
  assign eng_sample  = r_sample;
  assign m_valid     = r_mvalid;
  assign m_chan      = r_mchan;
  assign m_data      = r_mdata;
  assign err_timeout = r_err;

  // main FSM: accept -> start engine -> wait (with watchdog) -> hold result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= CW'(NCH - 1);
      r_chan   <= '0;
      r_sample <= '0;
      r_start  <= 1'b0;
      r_wd     <= '0;
      r_mvalid <= 1'b0;
      r_mchan  <= '0;
      r_mdata  <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_chan   <= w_idx;
          r_sample <= w_sel;
          r_last   <= w_idx;
          r_start  <= 1'b1;
          r_state  <= ISSUE;
        end
        ISSUE: begin
          r_wd    <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            r_mdata  <= eng_result;
            r_mchan  <= r_chan;
            r_mvalid <= 1'b1;
            r_state  <= OUT;
          end else if (w_timeout) begin
            // sample dropped; priority already moved on at acceptance
            r_state <= IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        OUT: if (m_ready) begin
          r_mvalid <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Bench: transaction-level model checked every cycle, directed scenarios with
// literal expectations, then randomized traffic with a randomized engine.
module tb_fir_channel_scheduler;
  import fir_pkg::*;
  localparam int WIDTH   = FIR_WIDTH;
  localparam int NCH     = FIR_NCH;
  localparam int TIMEOUT = FIR_TIMEOUT;
  localparam int CW      = $clog2(NCH);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH-1:0]       s_valid;
  logic [NCH*WIDTH-1:0] s_data;
  logic [NCH-1:0]       s_ready;
  logic                 eng_start;
  logic [CW-1:0]        eng_chan;
  logic [WIDTH-1:0]     eng_sample;
  logic                 eng_done;
  logic [WIDTH-1:0]     eng_result;
  logic                 m_valid;
  logic                 m_ready;
  logic [CW-1:0]        m_chan;
  logic [WIDTH-1:0]     m_data;
  logic                 err_timeout;
  logic                 err_clr;

  fir_channel_scheduler dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .eng_start(eng_start), .eng_chan(eng_chan), .eng_sample(eng_sample),
    .eng_done(eng_done), .eng_result(eng_result), .m_valid(m_valid),
    .m_ready(m_ready), .m_chan(m_chan), .m_data(m_data),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- engine responder ----------------
  bit               rand_mode = 0;
  int               resp_delay = -1;
  bit               resp_val_en = 0;
  logic [WIDTH-1:0] resp_val = '0;
  bit               force_done = 0;
  logic [WIDTH-1:0] force_val = '0;
  bit               armed = 0;
  int               cnt = 0;

  initial forever begin
    int d, r;
    @(negedge clk);
    if (eng_start === 1'b1) begin
      if (rand_mode) begin
        r = $urandom_range(0, 9);
        d = (r < 5) ? 64 : ((r < 8) ? int'($urandom_range(1, 20)) : -1);
      end else d = resp_delay;
      armed = (d > 0);
      cnt   = d;
    end
  end

  initial begin
    eng_done = 1'b0; eng_result = '0;
    forever begin
      @(posedge clk); #2;
      eng_done = 1'b0;
      if (armed) begin
        cnt--;
        if (cnt == 0) begin
          armed = 0; eng_done = 1'b1;
          eng_result = resp_val_en ? resp_val : WIDTH'($urandom);
        end
      end
      if (force_done) begin
        eng_done = 1'b1; eng_result = force_val;
      end else if (rand_mode && !eng_done && $urandom_range(0, 39) == 0) begin
        eng_done = 1'b1; eng_result = WIDTH'($urandom);
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  bit               md_busy, md_out, md_err;
  int               md_age, md_last = NCH - 1, md_chan, md_mchan;
  logic [WIDTH-1:0] md_samp, md_mdata;

  always @(negedge clk) begin : cmp
    int pick;
    logic [NCH-1:0] e_sr;
    bit to;
    to = 0;
    if (rst) begin
      md_busy = 0; md_out = 0; md_err = 0; md_age = 0; md_last = NCH - 1;
      md_chan = 0; md_mchan = 0; md_samp = '0; md_mdata = '0;
    end
    pick = -1;
    if (!rst && !md_busy)
      for (int i = 1; i <= NCH; i++) begin
        int c;
        c = (md_last + i) % NCH;
        if (pick < 0 && s_valid[c]) pick = c;
      end
    e_sr = '0;
    if (pick >= 0) e_sr[pick] = 1'b1;
    chk("s_ready", s_ready, e_sr);
    chk("eng_start", eng_start, md_busy && !md_out && md_age == 1);
    chk("eng_chan", eng_chan, md_chan);
    chk("eng_sample", eng_sample, md_samp);
    chk("m_valid", m_valid, md_out);
    chk("m_chan", m_chan, md_mchan);
    chk("m_data", m_data, md_mdata);
    chk("err_timeout", err_timeout, md_err);
    if (!rst) begin
      if (pick >= 0) begin
        md_busy = 1; md_age = 1; md_chan = pick; md_last = pick;
        md_samp = s_data[pick*WIDTH +: WIDTH];
      end else if (md_busy && md_out) begin
        if (m_ready) begin md_busy = 0; md_out = 0; end
      end else if (md_busy) begin
        // age 1 is the start cycle; waiting cycle count is age-2
        if (md_age >= 2 && eng_done) begin
          md_out = 1; md_mchan = md_chan; md_mdata = eng_result;
        end else if (md_age - 2 == TIMEOUT - 1) begin
          to = 1; md_busy = 0;
        end else md_age++;
      end
      md_err = to ? 1'b1 : (err_clr ? 1'b0 : md_err);
    end
  end

  // ---------------- directed + random stimulus ----------------
  function automatic int oh2i(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    tick();
    rst = 1'b1; s_valid = '0; m_ready = 1'b1; err_clr = 1'b0;
    force_done = 0; resp_val_en = 0; rand_mode = 0;
    tick(); tick(); tick();
    armed = 0;
    rst = 1'b0;
  endtask

  int                 gq[$], cq[$];
  int                 exp_ord[5] = '{0, 1, 2, 3, 0};
  bit                 flag_a, flag_b;
  logic [CW-1:0]      cap_c;
  logic [WIDTH-1:0]   cap_d;

  initial begin
    s_valid = '0; s_data = '0; m_ready = 1'b1; err_clr = 1'b0;

    // single channel 2, bit-exact extremes, exact latency
    do_reset();
    resp_delay = 5; resp_val = 18'h3FFFF; resp_val_en = 1;
    tick(); s_valid = 4'b0100; s_data[2*WIDTH +: WIDTH] = 18'h1FFFF;
    @(negedge clk); chk("c2_sready", s_ready, 4'b0100);
    tick(); s_valid = '0;
    @(negedge clk);
    chk("c2_start", eng_start, 1); chk("c2_echan", eng_chan, 2); chk("c2_esamp", eng_sample, 18'h1FFFF);
    repeat (5) tick();
    @(negedge clk); chk("c2_mv_done_cycle", m_valid, 0);
    tick();
    @(negedge clk);
    chk("c2_mvalid", m_valid, 1); chk("c2_mchan", m_chan, 2); chk("c2_mdata", m_data, 18'h3FFFF);

    // engine never answers: timeout, priority moves on, clear
    do_reset();
    resp_delay = -1;
    tick(); s_valid = '1;
    for (int t = 0; t < NCH * WIDTH / 32 + 3; t++) s_data = {s_data[NCH*WIDTH-33:0], $urandom};
    @(negedge clk); chk("to_first_grant", s_ready, 4'b0001);
    flag_a = 0;
    for (int i = 1; i <= 81; i++) begin
      tick(); @(negedge clk);
      if (m_valid !== 1'b0) flag_a = 1;
    end
    chk("to_err_before", err_timeout, 0);
    chk("to_no_mvalid", flag_a, 0);
    resp_delay = 2;
    tick(); @(negedge clk);
    chk("to_err_set", err_timeout, 1); chk("to_next_grant", s_ready, 4'b0010);
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    @(negedge clk); chk("to_err_clr", err_timeout, 0);

    // all channels busy, engine 64 cycles: rotation 0,1,2,3,0
    do_reset();
    resp_delay = 64;
    tick(); s_valid = '1;
    gq.delete(); cq.delete();
    for (int t = 0; t < 400 && gq.size() < 5; t++) begin
      @(negedge clk);
      if (s_ready != '0) gq.push_back(oh2i(s_ready));
      if (m_valid && m_ready) cq.push_back(int'(m_chan));
      tick();
    end
    chk("rr_grant_count", gq.size(), 5);
    chk("rr_result_count", cq.size(), 4);
    for (int i = 0; i < 5; i++) if (i < gq.size()) chk("rr_grant_order", gq[i], exp_ord[i]);
    for (int i = 0; i < 4; i++) if (i < cq.size()) chk("rr_mchan_order", cq[i], exp_ord[i]);

    // back-pressure: held result, no accepts, spurious done ignored
    do_reset();
    resp_delay = 3; m_ready = 1'b0;
    tick(); s_valid = 4'b0010;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (m_valid === 1'b1) break;
      tick();
    end
    chk("bp_reached_out", m_valid, 1);
    cap_c = m_chan; cap_d = m_data;
    chk("bp_chan", cap_c, 1);
    tick(); s_valid = '1;
    flag_a = 1; flag_b = 1;
    for (int i = 0; i < 20; i++) begin
      force_done = (i == 5); force_val = ~cap_d;
      @(negedge clk);
      if (!(m_valid === 1'b1 && m_chan === cap_c && m_data === cap_d)) flag_a = 0;
      if (s_ready !== '0) flag_b = 0;
      tick();
    end
    force_done = 0;
    chk("bp_stable", flag_a, 1); chk("bp_sready_zero", flag_b, 1);
    m_ready = 1'b1; s_valid = '0;
    @(negedge clk); chk("bp_handshake", m_valid, 1);
    tick(); @(negedge clk); chk("bp_released", m_valid, 0);

    // reset during WAIT, late engine reply must be ignored
    do_reset();
    resp_delay = 30;
    tick(); s_valid = '1; s_data[WIDTH-1:0] = 18'h2A5A5;
    tick(); s_valid = '0;
    repeat (8) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (25) tick();
    @(negedge clk);
    chk("rw_mvalid", m_valid, 0); chk("rw_mdata", m_data, 0); chk("rw_mchan", m_chan, 0);
    chk("rw_echan", eng_chan, 0); chk("rw_esamp", eng_sample, 0);
    chk("rw_start", eng_start, 0); chk("rw_err", err_timeout, 0);
    tick(); s_valid = '1;
    @(negedge clk); chk("rw_first_grant", s_ready, 4'b0001);

    // randomized traffic
    do_reset();
    rand_mode = 1;
    for (int i = 0; i < 5000; i++) begin
      tick();
      s_valid = ($urandom_range(0, 3) == 0) ? '0 : NCH'($urandom);
      for (int c = 0; c < NCH; c++) s_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      m_ready = ($urandom_range(0, 9) < 7);
      err_clr = ($urandom_range(0, 29) == 0);
      rst     = ($urandom_range(0, 599) == 0);
    end
    tick(); rst = 1'b0; rand_mode = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
